// File: rtl/ram_rd_pkg.sv
// Shared state type and default sizes for the RAM read path
// (burst reader, read-data stage and RAM-address stage).
package ram_rd_pkg;

    localparam int RD_SIZE_DATA = 8;
    localparam int RD_SIZE_ADDR = 8;
    localparam int RD_TIMEOUT   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/ram_rd_timeout.sv
// WAIT watchdog: down-counter loaded on clear, counts while enabled,
// terminal count flags the final allowed wait cycle.
module ram_rd_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Loaded with TIMEOUT-1 so that TIMEOUT wait cycles elapse before tc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= LOAD;
        end else if (i_en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign o_tc = (cnt == '0);

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read sequencer: issues one read per word, waits for the read-data
// stage, then streams each word out over valid/ready.
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | o_rd_en pulse for the current address, watchdog cleared
// WAIT  | waiting for i_rd_valid, watchdog running
// OUT   | word presented on o_data/o_valid until i_ready
// DONE  | one-cycle o_done
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int SIZE_DATA = RD_SIZE_DATA,
    parameter int SIZE_ADDR = RD_SIZE_ADDR,
    parameter int TIMEOUT   = RD_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_base_addr,
    input  logic [SIZE_ADDR:0]   i_len,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    input  logic                 i_rd_valid,
    input  logic [SIZE_DATA-1:0] i_rd_data,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    rd_state_e            state;
    rd_state_e            state_nxt;
    logic [SIZE_ADDR-1:0] addr_q;
    logic [SIZE_ADDR:0]   rem_q;
    logic [SIZE_DATA-1:0] data_q;
    logic                 err_q;
    logic                 tmo_clr;
    logic                 tmo_en;
    logic                 tmo_tc;

    ram_rd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (tmo_clr),
        .i_en    (tmo_en),
        .o_tc    (tmo_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A read-valid arriving on the terminal wait cycle loses to the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tmo_tc) begin
                    state_nxt = ST_DONE;
                end else if (i_rd_valid) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (i_ready) begin
                    state_nxt = (rem_q == (SIZE_ADDR+1)'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en = 1'b0;
        o_valid = 1'b0;
        o_done  = 1'b0;
        o_busy  = 1'b1;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        case (state)
            ST_IDLE:  o_busy = 1'b0;
            ST_ISSUE: begin
                o_rd_en = 1'b1;
                tmo_clr = 1'b1;
            end
            ST_WAIT:  tmo_en  = 1'b1;
            ST_OUT:   o_valid = 1'b1;
            ST_DONE:  o_done  = 1'b1;
            default:  o_busy  = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q <= i_base_addr;
                        rem_q  <= i_len;
                        err_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (tmo_tc) begin
                        err_q <= 1'b1;
                    end else if (i_rd_valid) begin
                        data_q <= i_rd_data;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        addr_q <= addr_q + SIZE_ADDR'(1);
                        rem_q  <= rem_q - (SIZE_ADDR+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ram_addr = addr_q;
    assign o_data     = data_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a RAM model answers reads with
// mem[a] = a ^ 8'hA5 after a programmable latency.
module tb_ram_burst_reader;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_base_addr = 8'h00;
    logic [8:0] i_len = 9'd0;
    logic       o_rd_en;
    logic [7:0] o_ram_addr;
    logic       i_rd_valid = 1'b0;
    logic [7:0] i_rd_data = 8'h00;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    ram_burst_reader #(
        .SIZE_DATA (8),
        .SIZE_ADDR (8),
        .TIMEOUT   (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_rd_en     (o_rd_en),
        .o_ram_addr  (o_ram_addr),
        .i_rd_valid  (i_rd_valid),
        .i_rd_data   (i_rd_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int         assert_n = 0;
    int         fail_n = 0;
    logic [7:0] mem [256];
    int         rd_lat = 1;
    bit         rsp_en = 1'b1;
    bit         stray_valid = 1'b0;
    int         pend = 0;
    logic [7:0] pend_addr = 8'h00;
    int         cyc = 0;
    int         done_n = 0;
    int         done_cyc = 0;
    int         valid_n = 0;
    int         hs_cyc = 0;
    logic       err_at_done = 1'b0;
    int         start_cyc = 0;
    logic [7:0] rd_addrs [$];
    int         rd_cycs [$];
    logic [7:0] out_data [$];
    logic [7:0] exp_addr [$];
    logic [7:0] exp_data [$];

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
    end

    // RAM read-data stage model
    always @(posedge i_clk) begin
        #1;
        i_rd_valid = stray_valid;
        if (!i_rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i_rd_valid = 1'b1;
                    i_rd_data  = mem[pend_addr];
                end
            end
            if (o_rd_en && rsp_en) begin
                pend      = rd_lat;
                pend_addr = o_ram_addr;
            end
        end
    end

    // Output monitor
    always @(negedge i_clk) begin
        cyc++;
        if (o_rd_en) begin
            rd_addrs.push_back(o_ram_addr);
            rd_cycs.push_back(cyc);
        end
        if (o_valid) valid_n++;
        if (o_valid && i_ready) begin
            out_data.push_back(o_data);
            hs_cyc = cyc;
        end
        if (o_done) begin
            done_n++;
            done_cyc    = cyc;
            err_at_done = o_err;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_sb();
        rd_addrs.delete();
        rd_cycs.delete();
        out_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic push_exp(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(8'(base + 8'(i)));
            exp_data.push_back(8'(base + 8'(i)) ^ 8'hA5);
        end
    endtask

    task automatic start_burst(input logic [7:0] base, input logic [8:0] len);
        @(posedge i_clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_len       = len;
        @(posedge i_clk);
        start_cyc = cyc;
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit to);
        int base_n;
        base_n = done_n;
        to = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge i_clk);
            if (done_n > base_n) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        assert_n++;
        if ({o_rd_en, o_busy, o_valid, o_done, o_err, o_ram_addr, o_data} !== 21'd0) begin
            fail_n++;
            $display("FAIL reset_outputs got=%h exp=0", {o_rd_en, o_busy, o_valid, o_done, o_err, o_ram_addr, o_data});
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_basic();
        bit to;
        int dn;
        logic [7:0] e, g;
        clear_sb();
        rd_lat = 1; rsp_en = 1'b1; i_ready = 1'b1;
        push_exp(8'h10, 4);
        dn = done_n;
        start_burst(8'h10, 9'd4);
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0) begin fail_n++; $display("FAIL basic_timeout got=%0d exp=0", to); end
        assert_n++;
        if (rd_addrs.size() != 4) begin fail_n++; $display("FAIL basic_rd_count got=%0d exp=4", rd_addrs.size()); end
        if (rd_cycs.size() >= 2) begin
            assert_n++;
            if (rd_cycs[0] != start_cyc + 1) begin fail_n++; $display("FAIL basic_first_rd_cycle got=%0d exp=%0d", rd_cycs[0], start_cyc + 1); end
            assert_n++;
            if (rd_cycs[1] - rd_cycs[0] != 3) begin fail_n++; $display("FAIL basic_word_period got=%0d exp=3", rd_cycs[1] - rd_cycs[0]); end
        end
        while (exp_addr.size() > 0) begin
            e = exp_addr.pop_front(); g = 8'hxx;
            if (rd_addrs.size() > 0) g = rd_addrs.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL basic_addr got=%h exp=%h", g, e); end
            e = exp_data.pop_front(); g = 8'hxx;
            if (out_data.size() > 0) g = out_data.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL basic_data got=%h exp=%h", g, e); end
        end
        assert_n++;
        if (done_n - dn != 1) begin fail_n++; $display("FAIL basic_done_count got=%0d exp=1", done_n - dn); end
        assert_n++;
        if (done_cyc != hs_cyc + 1) begin fail_n++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, hs_cyc + 1); end
        assert_n++;
        if (err_at_done !== 1'b0) begin fail_n++; $display("FAIL basic_err got=%b exp=0", err_at_done); end
        @(negedge i_clk);
        assert_n++;
        if (o_busy !== 1'b0) begin fail_n++; $display("FAIL basic_busy_after_done got=%b exp=0", o_busy); end
    endtask

    task automatic test_backpressure();
        bit to, seen;
        int n;
        logic [7:0] e, g;
        clear_sb();
        rd_lat = 1; rsp_en = 1'b1; i_ready = 1'b1;
        push_exp(8'h10, 4);
        start_burst(8'h10, 9'd4);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_rd_en) n++;
            if (n == 2) break;
            @(posedge i_clk); #1;
        end
        i_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin seen = 1'b1; break; end
        end
        assert_n++;
        if (seen !== 1'b1) begin fail_n++; $display("FAIL bp_word2_valid got=%b exp=1", seen); end
        for (int i = 0; i < 5; i++) begin
            assert_n++;
            if ({o_valid, o_rd_en, o_data} !== {1'b1, 1'b0, 8'hB4}) begin
                fail_n++;
                $display("FAIL bp_hold cycle=%0d got=%b/%b/%h exp=1/0/b4", i, o_valid, o_rd_en, o_data);
            end
            @(posedge i_clk); #1;
        end
        assert_n++;
        if (out_data.size() != 1) begin fail_n++; $display("FAIL bp_accepted_early got=%0d exp=1", out_data.size()); end
        i_ready = 1'b1;
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0) begin fail_n++; $display("FAIL bp_timeout got=%0d exp=0", to); end
        while (exp_data.size() > 0) begin
            e = exp_addr.pop_front(); g = 8'hxx;
            if (rd_addrs.size() > 0) g = rd_addrs.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL bp_addr got=%h exp=%h", g, e); end
            e = exp_data.pop_front(); g = 8'hxx;
            if (out_data.size() > 0) g = out_data.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL bp_data got=%h exp=%h", g, e); end
        end
        @(negedge i_clk);
    endtask

    task automatic test_wrap();
        bit to;
        logic [7:0] e, g;
        clear_sb();
        rd_lat = 2; rsp_en = 1'b1; i_ready = 1'b1;
        push_exp(8'hFE, 4);
        start_burst(8'hFE, 9'd4);
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0) begin fail_n++; $display("FAIL wrap_timeout got=%0d exp=0", to); end
        while (exp_data.size() > 0) begin
            e = exp_addr.pop_front(); g = 8'hxx;
            if (rd_addrs.size() > 0) g = rd_addrs.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL wrap_addr got=%h exp=%h", g, e); end
            e = exp_data.pop_front(); g = 8'hxx;
            if (out_data.size() > 0) g = out_data.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL wrap_data got=%h exp=%h", g, e); end
        end
        @(negedge i_clk);
    endtask

    task automatic test_zero();
        bit to;
        int vn;
        clear_sb();
        rd_lat = 1; rsp_en = 1'b1; i_ready = 1'b1;
        vn = valid_n;
        start_burst(8'h33, 9'd0);
        wait_done(10, to);
        assert_n++;
        if (to !== 1'b0) begin fail_n++; $display("FAIL zero_timeout got=%0d exp=0", to); end
        assert_n++;
        if (done_cyc != start_cyc + 1) begin fail_n++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 1); end
        assert_n++;
        if (rd_addrs.size() != 0 || valid_n != vn) begin
            fail_n++; $display("FAIL zero_activity rd=%0d valid=%0d exp=0/0", rd_addrs.size(), valid_n - vn);
        end
        @(negedge i_clk);
    endtask

    task automatic test_full();
        bit to;
        logic [7:0] e, g;
        clear_sb();
        rd_lat = 1; rsp_en = 1'b1; i_ready = 1'b1;
        push_exp(8'h00, 256);
        start_burst(8'h00, 9'd256);
        wait_done(1000, to);
        assert_n++;
        if (to !== 1'b0) begin fail_n++; $display("FAIL full_timeout got=%0d exp=0", to); end
        assert_n++;
        if (rd_addrs.size() != 256) begin fail_n++; $display("FAIL full_rd_count got=%0d exp=256", rd_addrs.size()); end
        if (rd_addrs.size() == 256) begin
            assert_n++;
            if (rd_addrs[255] !== 8'hFF) begin fail_n++; $display("FAIL full_last_addr got=%h exp=ff", rd_addrs[255]); end
        end
        while (exp_data.size() > 0) begin
            e = exp_data.pop_front(); g = 8'hxx;
            if (out_data.size() > 0) g = out_data.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL full_data got=%h exp=%h", g, e); end
        end
        @(negedge i_clk);
    endtask

    task automatic test_timeout();
        bit to;
        int vn;
        // latency 15: answer lands on the second-to-last allowed cycle
        clear_sb();
        rd_lat = 15; rsp_en = 1'b1; i_ready = 1'b1;
        start_burst(8'h40, 9'd1);
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0 || err_at_done !== 1'b0) begin fail_n++; $display("FAIL tmo_lat15 to=%0d err=%b exp=0/0", to, err_at_done); end
        assert_n++;
        if (out_data.size() != 1 || out_data[0] !== 8'hE5) begin fail_n++; $display("FAIL tmo_lat15_data n=%0d exp=1 word e5", out_data.size()); end
        @(negedge i_clk);
        // read-data stage silent
        clear_sb();
        rsp_en = 1'b0;
        vn = valid_n;
        start_burst(8'h50, 9'd2);
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0 || err_at_done !== 1'b1) begin fail_n++; $display("FAIL tmo_silent to=%0d err=%b exp=0/1", to, err_at_done); end
        assert_n++;
        if (rd_cycs.size() != 1 || done_cyc != rd_cycs[0] + 17) begin
            fail_n++; $display("FAIL tmo_silent_timing rd=%0d done=%0d exp=1 read, done 17 after issue", rd_cycs.size(), done_cyc);
        end
        assert_n++;
        if (valid_n != vn) begin fail_n++; $display("FAIL tmo_silent_valid got=%0d exp=0", valid_n - vn); end
        repeat (3) @(negedge i_clk);
        assert_n++;
        if ({o_err, o_busy} !== 2'b10) begin fail_n++; $display("FAIL tmo_err_sticky got=%b exp=10", {o_err, o_busy}); end
        // answer on the final wait cycle: timeout wins
        clear_sb();
        rsp_en = 1'b1; rd_lat = 16;
        vn = valid_n;
        start_burst(8'h58, 9'd1);
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0 || err_at_done !== 1'b1 || valid_n != vn) begin
            fail_n++; $display("FAIL tmo_race to=%0d err=%b valid=%0d exp=0/1/0", to, err_at_done, valid_n - vn);
        end
        @(negedge i_clk);
        // next start clears the flag
        clear_sb();
        rd_lat = 1;
        start_burst(8'h60, 9'd1);
        @(negedge i_clk);
        assert_n++;
        if (o_err !== 1'b0) begin fail_n++; $display("FAIL tmo_err_clear got=%b exp=0", o_err); end
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0 || out_data.size() != 1 || out_data[0] !== 8'hC5) begin
            fail_n++; $display("FAIL tmo_after_clear to=%0d n=%0d exp=0/1 word c5", to, out_data.size());
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        bit to;
        int n, dn;
        logic [7:0] e, g;
        clear_sb();
        rd_lat = 3; rsp_en = 1'b1; i_ready = 1'b1;
        start_burst(8'h70, 9'd4);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_rd_en) n++;
            if (n == 2) break;
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
        dn = done_n;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        assert_n++;
        if ({o_rd_en, o_busy, o_valid, o_done, o_err, o_ram_addr, o_data} !== 21'd0) begin
            fail_n++;
            $display("FAIL rstmid_outputs got=%h exp=0", {o_rd_en, o_busy, o_valid, o_done, o_err, o_ram_addr, o_data});
        end
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        assert_n++;
        if (done_n != dn) begin fail_n++; $display("FAIL rstmid_done got=%0d exp=0", done_n - dn); end
        clear_sb();
        rd_lat = 1;
        push_exp(8'h30, 2);
        start_burst(8'h30, 9'd2);
        wait_done(100, to);
        assert_n++;
        if (to !== 1'b0) begin fail_n++; $display("FAIL rstmid_rerun_timeout got=%0d exp=0", to); end
        while (exp_data.size() > 0) begin
            e = exp_addr.pop_front(); g = 8'hxx;
            if (rd_addrs.size() > 0) g = rd_addrs.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL rstmid_addr got=%h exp=%h", g, e); end
            e = exp_data.pop_front(); g = 8'hxx;
            if (out_data.size() > 0) g = out_data.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL rstmid_data got=%h exp=%h", g, e); end
        end
        @(negedge i_clk);
    endtask

    task automatic test_start_ignored();
        bit to;
        int dn;
        logic [7:0] e, g;
        clear_sb();
        rd_lat = 1; rsp_en = 1'b1; i_ready = 1'b1;
        push_exp(8'h80, 3);
        dn = done_n;
        start_burst(8'h80, 9'd3);
        repeat (4) begin @(posedge i_clk); #1; end
        i_start = 1'b1; i_base_addr = 8'hC0; i_len = 9'd1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(100, to);
        repeat (5) @(negedge i_clk);
        assert_n++;
        if (to !== 1'b0 || done_n - dn != 1 || o_busy !== 1'b0) begin
            fail_n++; $display("FAIL ign_start to=%0d done=%0d busy=%b exp=0/1/0", to, done_n - dn, o_busy);
        end
        assert_n++;
        if (rd_addrs.size() != 3) begin fail_n++; $display("FAIL ign_start_rd_count got=%0d exp=3", rd_addrs.size()); end
        while (exp_addr.size() > 0) begin
            e = exp_addr.pop_front(); g = 8'hxx;
            if (rd_addrs.size() > 0) g = rd_addrs.pop_front();
            assert_n++;
            if (g !== e) begin fail_n++; $display("FAIL ign_start_addr got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_stray();
        int vn;
        vn = valid_n;
        @(negedge i_clk);
        stray_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        stray_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        assert_n++;
        if (valid_n != vn || o_busy !== 1'b0) begin
            fail_n++; $display("FAIL stray_valid valid=%0d busy=%b exp=0/0", valid_n - vn, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_full();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        test_stray();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_n, fail_n);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read sequencer that sits directly upstream of the RAM read-data stage. On a start request it walks `i_len` consecutive RAM addresses from `i_base_addr` and issues one single-cycle read-enable per word. It waits for the read-data stage's valid pulse, then presents each word on a valid/ready output stream. It also reports completion, and flags a timeout if the read-data stage never answers.

## Interface
Parameters:
- `SIZE_DATA`, 8 — data word width.
- `SIZE_ADDR`, 8 — RAM address width.
- `TIMEOUT`, 16 — maximum cycles spent in WAIT before abort; must be ≥ 2.

Ports:
- `i_clk` in 1 — single clock; all logic on rising edge.
- `i_rst_n` in 1 — asynchronous, active-low reset.
- `i_start` in 1 — burst request, sampled only in IDLE.
- `i_base_addr` in `SIZE_ADDR` — first address of the burst.
- `i_len` in `SIZE_ADDR+1` — word count, 0 to 2^`SIZE_ADDR`.
- `o_rd_en` out 1 — read request pulse to the read-data stage.
- `o_ram_addr` out `SIZE_ADDR` — address for the current read; stable from ISSUE until the OUT handshake.
- `i_rd_valid` in 1 — valid pulse from the read-data stage.
- `i_rd_data` in `SIZE_DATA` — read data; sampled when `i_rd_valid` is high.
- `o_data` out `SIZE_DATA` — stream data.
- `o_valid` out 1 — stream valid.
- `i_ready` in 1 — stream ready.
- `o_busy` out 1 — high in every state except IDLE.
- `o_done` out 1 — one-cycle pulse at burst end.
- `o_err` out 1 — sticky timeout flag; cleared by the next accepted `i_start`.

## Operation
- Reset values: all outputs 0, state IDLE, internal address and remaining-count registers 0.
- FSM states: IDLE, ISSUE, WAIT, OUT, DONE.
- **IDLE**
  - `i_start`=1 latches base address and length, and clears `o_err`.
  - If `i_len`≠0, go to ISSUE.
  - If `i_len`=0, go to DONE; no reads are issued.
- **ISSUE:** `o_rd_en`=1 for exactly this cycle; next state is WAIT. The timeout counter resets to 0.
- **WAIT**
  - `i_rd_valid`=1 captures `i_rd_data` into the output register and moves to OUT.
  - Otherwise the counter increments. When it reaches `TIMEOUT`, set `o_err`=1 and go to DONE with no further reads.
- **OUT:** `o_valid`=1 and `o_data` is held stable until `i_ready`=1. On the handshake:
  - address increments, wrapping modulo 2^`SIZE_ADDR`;
  - remaining count decrements;
  - if the remaining count is now 0, go to DONE; otherwise go to ISSUE.
- **DONE:** `o_done`=1 for one cycle, then IDLE.
- Ignored inputs:
  - `i_start` outside IDLE.
  - `i_rd_valid` outside WAIT (stray or late pulses).
  - A `i_rd_valid` arriving in the same cycle the timeout fires; the timeout wins.
- Reset mid-burst: immediately returns to IDLE with all outputs 0. No `o_done` pulse is produced.

## Timing
- `i_start` sampled at edge N: `o_rd_en` is high in cycle N+1 and `o_busy` goes high in cycle N+1.
- Read-data stage answers k cycles after the `o_rd_en` edge: `o_valid` rises in the cycle after `i_rd_valid` is sampled.
- Minimum cost is 3 cycles per word (ISSUE, WAIT, OUT), with `i_rd_valid` in the first WAIT cycle and `i_ready` held high.
- `o_done` follows the final handshake by 1 cycle; `o_busy` drops the cycle after `o_done`.
- `i_len`=0: `o_done` appears in cycle N+1.
- Timeout: `o_err` and DONE occur `TIMEOUT` cycles after entering WAIT; `o_err` stays high while IDLE.

## Structure
- Package `ram_rd_pkg` holds:
  - the state enum typedef `rd_state_e`;
  - default `SIZE_DATA`/`SIZE_ADDR`/`TIMEOUT` localparams, shared with the read-data and RAM-address stages.
- One sub-module, `ram_rd_timeout`: a counter with clear, enable and terminal-count output, instantiated for the WAIT watchdog.
- The top level contains the FSM, address/count registers and output register.

## Test plan
- **Basic burst:** RAM preloaded with mem[a]=a^8'hA5; start with base=8'h10, len=4 and `i_ready`=1. Expect exactly 4 `o_rd_en` pulses at addresses 10,11,12,13, stream data B5,B4,B7,B6, then one `o_done` pulse and `o_err`=0.
- **Backpressure:** same burst with `i_ready` low for 5 cycles on word 2. Expect `o_data`=B4 held stable with `o_valid` high and no new `o_rd_en` until the handshake.
- **Wrap-around:** base=8'hFE, len=4. Expect addresses FE,FF,00,01 and data 5B,5A,A5,A4.
- **Zero and full length:**
  - len=0: `o_done` one cycle after `i_start`, no `o_rd_en`.
  - len=256 from base 0: 256 words, last address FF.
- **Timeout:** `i_rd_valid` tied 0, `TIMEOUT`=16. Expect `o_err`=1 and `o_done` 16 cycles after WAIT entry, with no `o_valid`. The next `i_start` clears `o_err`.
- **Reset and stray inputs:**
  - Assert `i_rst_n`=0 during WAIT of word 2: all outputs 0 next cycle, no `o_done`, and a new burst runs normally.
  - `i_start` pulsed mid-burst is ignored.
  - A stray `i_rd_valid` in IDLE produces no `o_valid`.
